// File: rtl/hsi_mse_pkg.sv
// Shared widths for the HSI MSE datapath.
// Sample, product and accumulator widths are set here once for every lane.
package hsi_mse_pkg;

    localparam int HM_DATA_WIDTH       = 16;
    localparam int HM_DATA_WIDTH_MUL   = 32;
    localparam int HM_DATA_WIDTH_ACC   = 48;
    localparam int HM_VECTOR_LENGTH_TB = 8;

endpackage : hsi_mse_pkg

// File: rtl/sq_df_acc_sq_df.sv
// Two-stage |a-b|^2 unit for unsigned samples.
// Stage 1 registers the absolute difference. Stage 2 registers its square.
module sq_df
    import hsi_mse_pkg::*;
#(
    parameter int DATA_WIDTH     = HM_DATA_WIDTH,
    parameter int DATA_WIDTH_MUL = HM_DATA_WIDTH_MUL
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [DATA_WIDTH-1:0]     a,
    input  logic [DATA_WIDTH-1:0]     b,
    output logic [DATA_WIDTH_MUL-1:0] sq
);

    logic [DATA_WIDTH-1:0] diff_q;

    // Subtract the smaller sample from the larger one so the unsigned result
    // never wraps and fits in DATA_WIDTH bits.
    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            diff_q <= '0;
            sq     <= '0;
        end else begin
            diff_q <= (a >= b) ? (a - b) : (b - a);
            sq     <= DATA_WIDTH_MUL'(diff_q) * DATA_WIDTH_MUL'(diff_q);
        end
    end

endmodule : sq_df

// File: rtl/sq_df_acc.sv
// Pipelined squared-difference accumulator: data_out += (v1 - v2)^2 per valid beat.
// The sum can be reseeded from initial_acc on any beat and wraps modulo 2^DATA_WIDTH_ACC.
module sq_df_acc
    import hsi_mse_pkg::*;
#(
    parameter int DATA_WIDTH     = HM_DATA_WIDTH,
    parameter int DATA_WIDTH_MUL = HM_DATA_WIDTH_MUL,
    parameter int DATA_WIDTH_ACC = HM_DATA_WIDTH_ACC
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      data_in_valid,
    input  logic                      initial_acc_en,
    input  logic [DATA_WIDTH_ACC-1:0] initial_acc,
    input  logic [DATA_WIDTH-1:0]     data_in_v1,
    input  logic [DATA_WIDTH-1:0]     data_in_v2,
    output logic                      data_out_valid,
    output logic [DATA_WIDTH_ACC-1:0] data_out
);

    logic [DATA_WIDTH_MUL-1:0] sq;

    // Side-band pipeline matching the two datapath stages of sq_df.
    logic                      valid_s1, valid_s2;
    logic                      init_en_s1, init_en_s2;
    logic [DATA_WIDTH_ACC-1:0] init_acc_s1, init_acc_s2;

    sq_df #(
        .DATA_WIDTH     (DATA_WIDTH),
        .DATA_WIDTH_MUL (DATA_WIDTH_MUL)
    ) u_sq_df (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (data_in_v1),
        .b     (data_in_v2),
        .sq    (sq)
    );

    // NOTE: every register here is a plain flop, so all of them get an explicit reset value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_s1    <= 1'b0;
            valid_s2    <= 1'b0;
            init_en_s1  <= 1'b0;
            init_en_s2  <= 1'b0;
            init_acc_s1 <= '0;
            init_acc_s2 <= '0;
        end else begin
            valid_s1    <= data_in_valid;
            valid_s2    <= valid_s1;
            init_en_s1  <= initial_acc_en;
            init_en_s2  <= init_en_s1;
            init_acc_s1 <= initial_acc;
            init_acc_s2 <= init_acc_s1;
        end
    end

    // data_out is the accumulator itself; a seed without a sample updates it
    // but does not raise data_out_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out       <= '0;
            data_out_valid <= 1'b0;
        end else begin
            data_out_valid <= valid_s2;
            if (valid_s2) begin
                data_out <= (init_en_s2 ? init_acc_s2 : data_out) + DATA_WIDTH_ACC'(sq);
            end else if (init_en_s2) begin
                data_out <= init_acc_s2;
            end
        end
    end

endmodule : sq_df_acc

// File: tb/tb_sq_df_acc.sv
// Randomized scoreboard bench for sq_df_acc.
// The driver predicts each cycle's output from the running-sum definition; a negedge monitor compares it.
`timescale 1ns/1ps
module tb_sq_df_acc;
    import hsi_mse_pkg::*;

    localparam int DW  = HM_DATA_WIDTH;
    localparam int AW  = HM_DATA_WIDTH_ACC;
    localparam int LAT = 3;

    typedef struct packed {
        logic          valid;
        logic [AW-1:0] data;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          data_in_valid = 1'b0;
    logic          initial_acc_en = 1'b0;
    logic [AW-1:0] initial_acc = '0;
    logic [DW-1:0] data_in_v1 = '0;
    logic [DW-1:0] data_in_v2 = '0;
    logic          data_out_valid;
    logic [AW-1:0] data_out;

    exp_t          exp_q[$];
    logic [AW-1:0] acc_model = '0;
    logic          mon_en = 1'b0;
    int            n_vec = 0;
    int            n_err = 0;

    sq_df_acc dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .data_in_valid  (data_in_valid),
        .initial_acc_en (initial_acc_en),
        .initial_acc    (initial_acc),
        .data_in_v1     (data_in_v1),
        .data_in_v2     (data_in_v2),
        .data_out_valid (data_out_valid),
        .data_out       (data_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: sum of squared differences since the last seed, modulo 2^AW.
    function automatic logic [AW-1:0] model_next(input logic [AW-1:0] acc, input logic v,
                                                 input logic en, input logic [AW-1:0] seed,
                                                 input logic [DW-1:0] a, input logic [DW-1:0] b);
        longint d;
        longint s;
        logic [AW-1:0] r;
        r = en ? seed : acc;
        if (v) begin
            d = longint'(a) - longint'(b);
            s = d * d;
            r = r + s[AW-1:0];
        end
        return r;
    endfunction

    // One clock of stimulus; the matching output is due LAT cycles later.
    task automatic step(input logic v, input logic en, input logic [AW-1:0] seed,
                        input logic [DW-1:0] a, input logic [DW-1:0] b);
        exp_t e;
        @(posedge clk);
        #1;
        data_in_valid  = v;
        initial_acc_en = en;
        initial_acc    = seed;
        data_in_v1     = a;
        data_in_v2     = b;
        acc_model      = model_next(acc_model, v, en, seed, a, b);
        e.valid        = v;
        e.data         = acc_model;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, '0);
    endtask

    // Release reset; the empty pipeline shows valid=0, data=0 for LAT cycles.
    task automatic release_reset();
        exp_t e;
        @(posedge clk);
        #1;
        rst_n          = 1'b1;
        data_in_valid  = 1'b0;
        initial_acc_en = 1'b0;
        acc_model      = '0;
        exp_q.delete();
        e = '0;
        for (int i = 0; i <= LAT; i++) exp_q.push_back(e);
        mon_en = 1'b1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (exp_q.size() == 0) begin
                check("scoreboard_underflow", 64'(exp_q.size()), 64'd1);
            end else begin
                e = exp_q.pop_front();
                check("data_out_valid", 64'(data_out_valid), 64'(e.valid));
                check("data_out", 64'(data_out), 64'(e.data));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] va[HM_VECTOR_LENGTH_TB];
        logic [DW-1:0] vb[HM_VECTOR_LENGTH_TB];
        logic [AW-1:0] seed;

        repeat (3) @(posedge clk);
        #1;
        check("reset_data_out", 64'(data_out), 64'd0);
        check("reset_valid", 64'(data_out_valid), 64'd0);
        release_reset();
        idle(2);

        // Seeded vector: expects 109, 109, 125, then hold at 125.
        step(1'b1, 1'b1, 48'd100, 16'd5, 16'd2);
        step(1'b1, 1'b0, 48'd0, 16'd10, 16'd10);
        step(1'b1, 1'b0, 48'd0, 16'd3, 16'd7);
        idle(4);

        // Negative difference: 65535^2.
        step(1'b1, 1'b1, 48'd0, 16'd0, 16'd65535);
        idle(2);

        // Back-to-back vectors; the second seed discards the first sum.
        step(1'b1, 1'b1, 48'd1000, 16'd300, 16'd20);
        step(1'b1, 1'b0, 48'd0, 16'd9, 16'd400);
        step(1'b1, 1'b1, 48'd7, 16'd12, 16'd4);
        step(1'b1, 1'b0, 48'd0, 16'd1, 16'd2);
        idle(2);

        // Wrap modulo 2^48.
        step(1'b1, 1'b1, {AW{1'b1}}, 16'd1, 16'd0);
        idle(2);

        // Seed without a sample: data_out changes, valid stays low, next beat adds on.
        step(1'b0, 1'b1, 48'd55, 16'd0, 16'd0);
        step(1'b1, 1'b0, 48'd0, 16'd4, 16'd1);
        idle(3);

        // Random vectors, sometimes back-to-back, sometimes with gaps.
        for (int k = 0; k < 3; k++) begin
            seed = {16'($urandom()), 32'($urandom())};
            for (int j = 0; j < HM_VECTOR_LENGTH_TB; j++) begin
                va[j] = DW'($urandom());
                vb[j] = DW'($urandom());
            end
            for (int j = 0; j < HM_VECTOR_LENGTH_TB; j++)
                step(1'b1, (j == 0), seed, va[j], vb[j]);
            if (k == 1) idle($urandom_range(3, 1));
        end
        idle(2);

        // Asynchronous reset mid-stream, with live inputs held during reset.
        step(1'b1, 1'b1, 48'd12345, 16'd40, 16'd3);
        step(1'b1, 1'b0, 48'd0, 16'd41, 16'd2);
        step(1'b1, 1'b0, 48'd0, 16'd42, 16'd1);
        step(1'b1, 1'b0, 48'd0, 16'd43, 16'd0);
        @(negedge clk);
        #2;
        mon_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        check("async_reset_data_out", 64'(data_out), 64'd0);
        check("async_reset_valid", 64'(data_out_valid), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        check("held_reset_data_out", 64'(data_out), 64'd0);
        release_reset();
        step(1'b1, 1'b0, 48'd0, 16'd20, 16'd10);
        step(1'b1, 1'b0, 48'd0, 16'd0, 16'd3);
        idle(5);

        @(posedge clk);
        mon_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_sq_df_acc
